// File: rtl/fetch_sequencer.sv
// Byte-serial Y86-64 instruction fetch: reads one byte per cycle, sizes the
// instruction from its opcode byte and hands a complete bundle to decode.
module fetch_sequencer #(
    parameter int DATA_WID  = 64,
    parameter int MEM_BYTES = 2048
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pc_load,
    input  logic [DATA_WID-1:0] pc_in,
    output logic                mem_rd,
    output logic [DATA_WID-1:0] mem_addr,
    input  logic [7:0]          mem_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [3:0]          icode,
    output logic [3:0]          ifun,
    output logic [3:0]          rA,
    output logic [3:0]          rB,
    output logic [DATA_WID-1:0] valC,
    output logic [DATA_WID-1:0] valP,
    output logic                out_halt,
    output logic                out_ins_err,
    output logic                out_adr_err
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_OUT, S_HALTED} state_t;

    localparam logic [DATA_WID-1:0] MEM_LIMIT = DATA_WID'(MEM_BYTES);

    function automatic logic [3:0] ins_len(input logic [3:0] c);
        case (c)
            4'h2, 4'h6, 4'hA, 4'hB: ins_len = 4'd2;
            4'h7, 4'h8:             ins_len = 4'd9;
            4'h3, 4'h4, 4'h5:       ins_len = 4'd10;
            default:                ins_len = 4'd1;
        endcase
    endfunction

    function automatic logic has_reg(input logic [3:0] c);
        case (c)
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: has_reg = 1'b1;
            default:                                  has_reg = 1'b0;
        endcase
    endfunction

    function automatic logic has_const(input logic [3:0] c);
        case (c)
            4'h3, 4'h4, 4'h5, 4'h7, 4'h8: has_const = 1'b1;
            default:                      has_const = 1'b0;
        endcase
    endfunction

    state_t                state_reg;
    logic [DATA_WID-1:0]   pc_reg;
    logic [3:0]            idx_reg;
    logic                  pend_reg;
    logic [3:0]            pend_idx_reg;
    logic [3:0]            len_reg;
    logic                  len_known_reg;
    logic [3:0]            icode_reg, ifun_reg, ra_reg, rb_reg;
    logic [DATA_WID-1:0]   valc_reg, valp_reg;
    logic                  halt_reg, ins_err_reg, adr_err_reg, valid_reg;

    logic                  capture, first_byte, len_known, need_issue, addr_bad;
    logic                  fetch_err, go_out, any_status, restart, cap_const;
    logic [3:0]            cur_len, const_start, const_idx;
    logic [DATA_WID-1:0]   fetch_addr, restart_pc, valc_next;

    // The opcode byte sizes the instruction in the same cycle it arrives,
    // so byte 1 can be issued without a bubble.
    assign first_byte  = pend_reg && (pend_idx_reg == 4'd0);
    assign cur_len     = first_byte ? ins_len(mem_rdata[7:4]) : len_reg;
    assign len_known   = len_known_reg || first_byte;
    assign need_issue  = len_known ? (idx_reg < cur_len) : (idx_reg == 4'd0);
    assign fetch_addr  = pc_reg + {{(DATA_WID-4){1'b0}}, idx_reg};
    assign addr_bad    = fetch_addr >= MEM_LIMIT;

    assign mem_rd      = (state_reg == S_FETCH) && need_issue && !addr_bad && !pc_load && !rst;
    assign mem_addr    = fetch_addr;

    assign capture     = (state_reg == S_FETCH) && pend_reg && !pc_load;
    assign fetch_err   = (state_reg == S_FETCH) && need_issue && addr_bad;
    assign go_out      = fetch_err || (capture && (pend_idx_reg == cur_len - 4'd1));

    assign any_status  = halt_reg || ins_err_reg || adr_err_reg;
    assign restart     = pc_load || ((state_reg == S_OUT) && out_ready && !any_status);
    assign restart_pc  = pc_load ? pc_in : valp_reg;

    assign const_start = has_reg(icode_reg) ? 4'd2 : 4'd1;
    assign const_idx   = pend_idx_reg - const_start;
    assign cap_const   = capture && (pend_idx_reg != 4'd0) && has_const(icode_reg)
                         && (pend_idx_reg >= const_start);

    generate
        for (genvar gi = 0; gi < DATA_WID / 8; gi++) begin : g_valc
            assign valc_next[8*gi +: 8] = (cap_const && (const_idx == 4'(gi)))
                                          ? mem_rdata : valc_reg[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            pc_reg        <= '0;
            idx_reg       <= 4'd0;
            pend_reg      <= 1'b0;
            pend_idx_reg  <= 4'd0;
            len_reg       <= 4'd0;
            len_known_reg <= 1'b0;
            icode_reg     <= 4'h0;
            ifun_reg      <= 4'h0;
            ra_reg        <= 4'hF;
            rb_reg        <= 4'hF;
            valc_reg      <= '0;
            valp_reg      <= '0;
            halt_reg      <= 1'b0;
            ins_err_reg   <= 1'b0;
            adr_err_reg   <= 1'b0;
            valid_reg     <= 1'b0;
        end else if (restart) begin
            // Any byte still in flight is dropped by clearing pend_reg.
            state_reg     <= S_FETCH;
            pc_reg        <= restart_pc;
            idx_reg       <= 4'd0;
            pend_reg      <= 1'b0;
            len_known_reg <= 1'b0;
            icode_reg     <= 4'h0;
            ifun_reg      <= 4'h0;
            ra_reg        <= 4'hF;
            rb_reg        <= 4'hF;
            valc_reg      <= '0;
            valp_reg      <= restart_pc;
            halt_reg      <= 1'b0;
            ins_err_reg   <= 1'b0;
            adr_err_reg   <= 1'b0;
            valid_reg     <= 1'b0;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    pend_reg     <= mem_rd;
                    pend_idx_reg <= idx_reg;
                    if (mem_rd)
                        idx_reg <= idx_reg + 4'd1;
                    if (capture) begin
                        if (first_byte) begin
                            icode_reg     <= mem_rdata[7:4];
                            ifun_reg      <= mem_rdata[3:0];
                            len_reg       <= cur_len;
                            len_known_reg <= 1'b1;
                            valp_reg      <= pc_reg + {{(DATA_WID-4){1'b0}}, cur_len};
                            halt_reg      <= (mem_rdata[7:4] == 4'h0);
                            ins_err_reg   <= (mem_rdata[7:4] > 4'hB);
                        end else if ((pend_idx_reg == 4'd1) && has_reg(icode_reg)) begin
                            ra_reg <= mem_rdata[7:4];
                            rb_reg <= mem_rdata[3:0];
                        end
                        valc_reg <= valc_next;
                    end
                    if (fetch_err)
                        adr_err_reg <= 1'b1;
                    if (go_out) begin
                        state_reg <= S_OUT;
                        valid_reg <= 1'b1;
                    end
                end
                S_OUT: begin
                    // A clean handshake is handled by restart; here only a
                    // bundle carrying a status bit is being accepted.
                    if (out_ready) begin
                        state_reg <= S_HALTED;
                        valid_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid   = valid_reg;
    assign icode       = icode_reg;
    assign ifun        = ifun_reg;
    assign rA          = ra_reg;
    assign rB          = rb_reg;
    assign valC        = valc_reg;
    assign valP        = valp_reg;
    assign out_halt    = halt_reg;
    assign out_ins_err = ins_err_reg;
    assign out_adr_err = adr_err_reg;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a byte-level instruction model predicts every
// cycle's memory requests and bundles; directed steps pin literal results.
module tb_fetch_sequencer;
    localparam int MEM_BYTES = 2048;
    localparam int M_IDLE = 0, M_FETCH = 1, M_PRESENT = 2, M_HALT = 3;

    logic        clk, rst, pc_load, mem_rd, out_valid, out_ready;
    logic        out_halt, out_ins_err, out_adr_err;
    logic [63:0] pc_in, mem_addr, valC, valP;
    logic [7:0]  mem_rdata;
    logic [3:0]  icode, ifun, rA, rB;

    logic [7:0]  mem [0:MEM_BYTES-1];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          rd_count = 0;
    logic [63:0] last_addr = '0;

    typedef struct {
        logic [63:0] pc, valc, valp;
        logic [3:0]  icode, ifun, ra, rb;
        logic        halt, ins, adr;
        int          n_issue, done;
    } bundle_t;

    fetch_sequencer #(.DATA_WID(64), .MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .rst(rst), .pc_load(pc_load), .pc_in(pc_in),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
        .valC(valC), .valP(valP),
        .out_halt(out_halt), .out_ins_err(out_ins_err), .out_adr_err(out_adr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered single-port memory; unread cycles return junk.
    initial mem_rdata = 8'h00;
    always @(posedge clk) mem_rdata <= mem_rd ? mem[mem_addr[10:0]] : 8'($urandom);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // What fetching at pc must produce, straight from the instruction format.
    function automatic bundle_t model_fetch(input logic [63:0] pc);
        bundle_t     b;
        logic [7:0]  b0, rr;
        logic [63:0] room;
        int          len, start, base;
        b.pc = pc; b.icode = 4'h0; b.ifun = 4'h0; b.ra = 4'hF; b.rb = 4'hF;
        b.valc = '0; b.valp = pc; b.halt = 1'b0; b.ins = 1'b0; b.adr = 1'b0;
        b.n_issue = 0; b.done = 1;
        if (pc >= 64'(MEM_BYTES)) begin
            b.adr = 1'b1;
            return b;
        end
        base = int'(pc);
        b0 = mem[base];
        b.icode = b0[7:4];
        b.ifun  = b0[3:0];
        case (b0[7:4])
            4'h2, 4'h6, 4'hA, 4'hB: len = 2;
            4'h7, 4'h8:             len = 9;
            4'h3, 4'h4, 4'h5:       len = 10;
            default:                len = 1;
        endcase
        room = 64'(MEM_BYTES) - pc;
        b.n_issue = (room < 64'(len)) ? int'(room) : len;
        b.adr  = (b.n_issue < len);
        b.done = b.n_issue + 1;
        b.halt = (b0[7:4] == 4'h0);
        b.ins  = (b0[7:4] > 4'hB);
        b.valp = pc + 64'(len);
        if ((len == 2 || len == 10) && b.n_issue >= 2) begin
            rr = mem[base + 1];
            b.ra = rr[7:4];
            b.rb = rr[3:0];
        end
        start = (len == 10) ? 2 : 1;
        if (len >= 9)
            for (int j = 0; j < 8; j++)
                if (start + j < b.n_issue)
                    b.valc[8*j +: 8] = mem[base + start + j];
        return b;
    endfunction

    // Cycle-by-cycle comparison against the model.
    initial begin : compare
        int      mode;
        int      k;
        bit      known;
        bit      exp_rd;
        bundle_t b;
        mode = M_IDLE; k = 0; known = 1'b0;
        b = model_fetch(64'(MEM_BYTES));
        forever begin
            @(negedge clk);
            if (known) begin
                exp_rd = (mode == M_FETCH) && (k < b.n_issue) && !pc_load && !rst;
                chk("mem_rd", 64'(mem_rd), 64'(exp_rd));
                if (exp_rd)
                    chk("mem_addr", mem_addr, b.pc + 64'(k));
                chk("out_valid", 64'(out_valid), 64'(mode == M_PRESENT));
                if (mode == M_PRESENT) begin
                    chk("icode", 64'(icode), 64'(b.icode));
                    chk("ifun", 64'(ifun), 64'(b.ifun));
                    chk("rA", 64'(rA), 64'(b.ra));
                    chk("rB", 64'(rB), 64'(b.rb));
                    chk("valC", valC, b.valc);
                    chk("valP", valP, b.valp);
                    chk("out_halt", 64'(out_halt), 64'(b.halt));
                    chk("out_ins_err", 64'(out_ins_err), 64'(b.ins));
                    chk("out_adr_err", 64'(out_adr_err), 64'(b.adr));
                end
            end
            if (mem_rd) begin
                rd_count++;
                last_addr = mem_addr;
            end
            if (rst) begin
                mode = M_IDLE;
                known = 1'b1;
            end else if (pc_load) begin
                b = model_fetch(pc_in);
                k = 0;
                mode = M_FETCH;
            end else if (mode == M_FETCH) begin
                k++;
                if (k == b.done)
                    mode = M_PRESENT;
            end else if (mode == M_PRESENT && out_ready) begin
                $display("bundle pc=0x%0h icode=%0h ifun=%0h rA=%0h rB=%0h valC=0x%0h valP=0x%0h h/i/a=%0b%0b%0b",
                         b.pc, icode, ifun, rA, rB, valC, valP, out_halt, out_ins_err, out_adr_err);
                if (b.halt || b.ins || b.adr)
                    mode = M_HALT;
                else begin
                    b = model_fetch(b.valp);
                    k = 0;
                    mode = M_FETCH;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [63:0] a);
        pc_load = 1'b1;
        pc_in   = a;
        step();
        pc_load = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            seen = out_valid;
        end
        chk({name, " bundle arrives"}, 64'(seen), 64'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        bundle_t bm;
        int      c0, r0;
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h10;
        mem[0] = 8'h30; mem[1] = 8'hF2; mem[2] = 8'h0A;
        for (int i = 3; i < 10; i++) mem[i] = 8'h00;
        mem[10] = 8'h70; mem[11] = 8'h00; mem[12] = 8'h01;
        for (int i = 13; i < 19; i++) mem[i] = 8'h00;
        mem[19] = 8'h60; mem[20] = 8'h12; mem[21] = 8'h90; mem[22] = 8'h00;
        mem[8'h30] = 8'hC0;
        mem[MEM_BYTES-2] = 8'h30; mem[MEM_BYTES-1] = 8'hF2;
        mem[8'h40] = 8'h10; mem[8'h41] = 8'h00;

        // Pin the model on hand-derived values.
        bm = model_fetch(64'd10);
        chk("model jXX valP", bm.valp, 64'd19);
        chk("model jXX valC", bm.valc, 64'h100);
        bm = model_fetch(64'(MEM_BYTES - 2));
        chk("model adr issues", 64'(bm.n_issue), 64'd2);

        rst = 1'b1; pc_load = 1'b0; pc_in = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset mem_rd", 64'(mem_rd), 64'd0);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset icode", 64'(icode), 64'd0);
        chk("reset rA", 64'(rA), 64'hF);
        chk("reset rB", 64'(rB), 64'hF);
        chk("reset valC", valC, 64'd0);
        chk("reset valP", valP, 64'd0);
        chk("reset status", 64'({out_halt, out_ins_err, out_adr_err}), 64'd0);

        // irmovq with backpressure
        step();
        load(64'd0);
        c0 = cyc;
        wait_valid("irmovq");
        chk("irmovq valid cycle", 64'(cyc - c0), 64'd11);
        chk("irmovq icode", 64'(icode), 64'h3);
        chk("irmovq rA", 64'(rA), 64'hF);
        chk("irmovq rB", 64'(rB), 64'h2);
        chk("irmovq valC", valC, 64'h0A);
        chk("irmovq valP", valP, 64'd10);
        repeat (5) begin
            @(negedge clk);
            chk("stall valid", 64'(out_valid), 64'd1);
            chk("stall mem_rd", 64'(mem_rd), 64'd0);
            chk("stall valC", valC, 64'h0A);
        end
        step();
        out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("after handshake mem_rd", 64'(mem_rd), 64'd1);
        chk("after handshake mem_addr", mem_addr, 64'd10);
        chk("after handshake valid", 64'(out_valid), 64'd0);

        wait_valid("jXX");
        chk("jXX icode", 64'(icode), 64'h7);
        chk("jXX rA", 64'(rA), 64'hF);
        chk("jXX rB", 64'(rB), 64'hF);
        chk("jXX valC", valC, 64'h100);
        chk("jXX valP", valP, 64'd19);
        step();
        wait_valid("OPq");
        chk("OPq rA", 64'(rA), 64'h1);
        chk("OPq rB", 64'(rB), 64'h2);
        chk("OPq valP", valP, 64'd21);
        step();
        wait_valid("ret");
        chk("ret icode", 64'(icode), 64'h9);
        chk("ret valP", valP, 64'd22);
        step();
        wait_valid("halt");
        chk("halt out_halt", 64'(out_halt), 64'd1);
        step();
        r0 = rd_count;
        repeat (10) @(negedge clk);
        chk("halted reads", 64'(rd_count - r0), 64'd0);
        chk("halted valid", 64'(out_valid), 64'd0);

        // invalid opcode
        step();
        load(64'h30);
        wait_valid("invalid");
        chk("invalid ins_err", 64'(out_ins_err), 64'd1);
        chk("invalid icode", 64'(icode), 64'hC);
        chk("invalid valP", valP, 64'h31);
        step();
        repeat (3) step();

        // address error at the top of memory
        r0 = rd_count;
        load(64'(MEM_BYTES - 2));
        wait_valid("adr");
        chk("adr reads", 64'(rd_count - r0), 64'd2);
        chk("adr last addr", last_addr, 64'(MEM_BYTES - 1));
        chk("adr out_adr_err", 64'(out_adr_err), 64'd1);
        chk("adr icode", 64'(icode), 64'h3);
        chk("adr rB", 64'(rB), 64'h2);
        chk("adr valC", valC, 64'd0);
        step();
        repeat (3) step();

        // redirect in cycle 4 of a 10-byte fetch
        load(64'd0);
        repeat (4) step();
        pc_load = 1'b1;
        pc_in   = 64'h40;
        @(negedge clk);
        chk("redirect cycle mem_rd", 64'(mem_rd), 64'd0);
        step();
        pc_load = 1'b0;
        @(negedge clk);
        chk("redirect issue", 64'(mem_rd), 64'd1);
        chk("redirect addr", mem_addr, 64'h40);
        wait_valid("redirect nop");
        chk("redirect icode", 64'(icode), 64'h1);
        chk("redirect valP", valP, 64'h41);
        step();
        wait_valid("redirect halt");
        chk("redirect halt valP", valP, 64'h42);
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
